seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255; number of consecutive identical samples required before a dwell is accepted.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 an  input  4  digit enables, active-low, one-hot; bit i selects digit i.
REQ-005 seg  input  7  segment lines, active-low, bit order gfedcba (bit0 = a).
REQ-006 digit0..digit3  output  4 each  last accepted BCD value per digit.
REQ-007 digit_valid  output  4  bit i is high when digit i holds a value decoded from a legal pattern.
REQ-008 frame_done  output  1  one-cycle pulse when all four digits have been captured since the previous pulse.
REQ-009 err  output  1  one-cycle pulse on an illegal segment pattern or a multi-hot anode dwell.

Function
REQ-010 an and seg SHALL be registered once before any comparison or decode.
REQ-011 Legal seg codes: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h; every other code is illegal.
REQ-012 A stability counter SHALL increment while the registered {an,seg} equals its previous value and clear to 0 on any change; it saturates.
REQ-013 Exactly one accept event per dwell: when a pattern has been stable for STABLE_CYCLES samples; no further accepts until {an,seg} changes.
REQ-014 Latency: pattern applied before edge 1 and held; outputs reflect the accept after edge STABLE_CYCLES+1.
REQ-015 Accept, one-hot an, legal seg: digit[i] <= decoded value, digit_valid[i] <= 1, captured-mask bit i set.
REQ-016 Accept, one-hot an, illegal seg: digit[i] unchanged, digit_valid[i] <= 0, captured-mask bit i set, err pulses.
REQ-017 Accept, an = Fh (blank): no digit change, no err, mask unchanged.
REQ-018 Accept, an has two or more low bits: no digit change, err pulses, mask unchanged.
REQ-019 frame_done pulses in the cycle after the mask becomes Fh; the mask clears in the same cycle, and an accept in that cycle sets its bit in the fresh mask.
REQ-020 Re-capture of an already-masked digit before frame completion updates that digit without changing the mask.
REQ-021 err and frame_done SHALL never stay high for two consecutive cycles from a single dwell.

Reset
REQ-022 While reset is high at an edge: digit0..3 = 0, digit_valid = 0, frame_done = 0, err = 0, mask = 0, stability counter = 0, input register = {Fh,7Fh}.
REQ-023 Reset mid-dwell SHALL discard the partial count; a pattern held across reset release needs a full STABLE_CYCLES again after release.

Structure
REQ-024 The segment code constants, STABLE_CYCLES default and blank anode value (Fh) SHALL live in a shared package seg7_pkg used by this block and the existing BCD-to-segment encoder.
REQ-025 The combinational pattern-to-BCD lookup with a legal flag SHALL be one sub-module, seg7_to_bcd; stability counter, mask and output registers stay in the top.

Verification (STABLE_CYCLES=4)
REQ-026 an=Eh, seg=30h held 6 cycles -> digit0=3, digit_valid=0001b after edge 5, no err, single accept.
REQ-027 Scan an=E,D,B,7 with seg 79h,24h,30h,19h, 5 cycles each -> digits 1,2,3,4, digit_valid=Fh, frame_done one pulse after the fourth accept, mask cleared.
REQ-028 an=Dh, seg=7Fh held 5 cycles -> err one pulse, digit_valid[1]=0, digit1 unchanged.
REQ-029 an=Ch, seg=40h held 5 cycles -> err one pulse, no digit or mask change; an=Fh held -> no err.
REQ-030 an=Eh, seg=12h held 3 cycles then seg=10h 5 cycles -> only digit0=9 accepted, never 5.
REQ-031 Reset asserted at cycle 3 of an an=Bh, seg=02h dwell, released and held -> no accept until 4 further stable samples, then digit2=6.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg -- segment codes, scan defaults and anode helpers shared by the
//             seven-segment encoder and decoder.  Rev 1.0
// ============================================================================
package seg7_pkg;

  // Active-low segment codes, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_BLANK              = 4'hF;
  localparam int         STABLE_CYCLES_DEFAULT = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } scan_sample_t;

  typedef enum logic [1:0] {
    AN_CLS_BLANK  = 2'd0,
    AN_CLS_ONEHOT = 2'd1,
    AN_CLS_MULTI  = 2'd2
  } an_class_e;

  function automatic an_class_e classify_an(input logic [3:0] an);
    case ($countones(~an))
      0:       return AN_CLS_BLANK;
      1:       return AN_CLS_ONEHOT;
      default: return AN_CLS_MULTI;
    endcase
  endfunction

  // Position of the lowest driven (low) anode; meaningful only for one-hot.
  function automatic logic [1:0] an_index(input logic [3:0] an);
    if (!an[0])      return 2'd0;
    else if (!an[1]) return 2'd1;
    else if (!an[2]) return 2'd2;
    else             return 2'd3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_to_bcd.sv
`default_nettype none
// ============================================================================
// seg7_to_bcd -- combinational segment-pattern to BCD lookup with legal flag.
//                Rev 1.0
// ============================================================================
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       legal_o
);

  always_comb begin
    bcd_o   = 4'd0;
    legal_o = 1'b1;
    case (seg_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: legal_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// seg_scan_decoder -- recovers BCD digits from a multiplexed, active-low
//                     seven-segment scan after a stable dwell.  Rev 1.0
// ============================================================================
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       err
);

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  scan_sample_t sample_d, sample_q;
  logic [7:0]   cnt_d, cnt_q;
  logic [3:0]   digit_d [0:3];
  logic [3:0]   digit_q [0:3];
  logic [3:0]   valid_d, valid_q;
  logic [3:0]   mask_d, mask_q;
  logic         frame_d, frame_q;
  logic         err_d, err_q;

  logic         accept_w;
  an_class_e    cls_w;
  logic [1:0]   idx_w;
  logic [3:0]   bcd_w;
  logic         legal_w;

  assign sample_d = {an, seg};

  seg7_to_bcd u_lookup (
    .seg_i   (sample_q.seg),
    .bcd_o   (bcd_w),
    .legal_o (legal_w)
  );

  assign cls_w = classify_an(sample_q.an);
  assign idx_w = an_index(sample_q.an);

  // cnt_q counts repeats after the first sample, so STABLE_CYCLES-1 marks a full dwell;
  // saturating above that value makes the accept fire once per dwell.
  assign accept_w = (cnt_q == STABLE_W - 8'd1);

  always_comb begin
    cnt_d = 8'd0;
    if (sample_d == sample_q) begin
      cnt_d = (cnt_q == STABLE_W) ? cnt_q : cnt_q + 8'd1;
    end
  end

  always_comb begin
    digit_d = digit_q;
    valid_d = valid_q;
    frame_d = (mask_q == 4'hF);
    mask_d  = frame_d ? 4'h0 : mask_q;
    err_d   = 1'b0;
    if (accept_w) begin
      case (cls_w)
        AN_CLS_ONEHOT: begin
          mask_d[idx_w] = 1'b1;
          if (legal_w) begin
            digit_d[idx_w] = bcd_w;
            valid_d[idx_w] = 1'b1;
          end else begin
            valid_d[idx_w] = 1'b0;
            err_d          = 1'b1;
          end
        end
        AN_CLS_MULTI: err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= {AN_BLANK, SEG_BLANK};
      cnt_q    <= 8'd0;
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
      valid_q  <= 4'h0;
      mask_q   <= 4'h0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit2      = digit_q[2];
  assign digit3      = digit_q[3];
  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_decoder -- directed self-checking bench for seg_scan_decoder
//                        with STABLE_CYCLES = 4.  Rev 1.0
// ============================================================================
module tb_seg_scan_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] an = 4'hF;
  logic [6:0] seg = 7'h7F;
  logic [3:0] digit0, digit1, digit2, digit3, digit_valid;
  logic       frame_done, err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int fd_pulses = 0;

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err)        err_pulses++;
    if (frame_done) fd_pulses++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1; an = 4'hF; seg = 7'h7F;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin
      errors++; $display("FAIL reset_digits: got %h expected 0000", {digit3, digit2, digit1, digit0});
    end
    checks++;
    if ({digit_valid, frame_done, err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got valid=%b fd=%b err=%b expected 0", digit_valid, frame_done, err);
    end
  endtask

  task automatic test_single_digit;
    int e0;
    do_reset();
    e0 = err_pulses;
    an = 4'hE; seg = 7'h30;
    step(4);
    checks++;
    if (digit_valid !== 4'b0000) begin
      errors++; $display("FAIL single_early: got valid=%b expected 0000", digit_valid);
    end
    step(1);
    checks++;
    if (digit0 !== 4'd3 || digit_valid !== 4'b0001) begin
      errors++; $display("FAIL single_accept: got d0=%0d valid=%b expected 3 0001", digit0, digit_valid);
    end
    step(1);
    checks++;
    if (err_pulses - e0 !== 0) begin
      errors++; $display("FAIL single_err: got %0d err pulses expected 0", err_pulses - e0);
    end
  endtask

  task automatic test_scan_frame;
    logic [3:0] ans  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] segs [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
    int f0;
    do_reset();
    f0 = fd_pulses;
    for (int j = 0; j < 4; j++) begin
      an = ans[j]; seg = segs[j];
      step(5);
    end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== 16'h4321 || digit_valid !== 4'hF) begin
      errors++; $display("FAIL scan_digits: got %h valid=%b expected 4321 1111", {digit3, digit2, digit1, digit0}, digit_valid);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL scan_fd_early: got %b expected 0", frame_done);
    end
    an = 4'hF; seg = 7'h7F;
    step(1);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL scan_fd_pulse: got %b expected 1", frame_done);
    end
    step(1);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL scan_fd_single: got %b expected 0", frame_done);
    end
    // fresh mask: one new capture must not complete a frame
    an = 4'hE; seg = 7'h79;
    step(7);
    checks++;
    if (fd_pulses - f0 !== 1) begin
      errors++; $display("FAIL scan_mask_clear: got %0d frame pulses expected 1", fd_pulses - f0);
    end
  endtask

  task automatic test_illegal_seg;
    int e0;
    e0 = err_pulses;
    an = 4'hD; seg = 7'h7F;
    step(5);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL illegal_err: got %b expected 1", err);
    end
    step(1);
    checks++;
    if (err !== 1'b0 || err_pulses - e0 !== 1) begin
      errors++; $display("FAIL illegal_pulse: got err=%b pulses=%0d expected 0 1", err, err_pulses - e0);
    end
    checks++;
    if (digit_valid !== 4'b1101 || digit1 !== 4'd2) begin
      errors++; $display("FAIL illegal_digit: got valid=%b d1=%0d expected 1101 2", digit_valid, digit1);
    end
  endtask

  task automatic test_multi_hot_and_blank;
    int e0;
    e0 = err_pulses;
    an = 4'hC; seg = 7'h40;
    step(5);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL multihot_err: got %b expected 1", err);
    end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== 16'h4321 || digit_valid !== 4'b1101) begin
      errors++; $display("FAIL multihot_digits: got %h valid=%b expected 4321 1101", {digit3, digit2, digit1, digit0}, digit_valid);
    end
    an = 4'hF;
    step(8);
    checks++;
    if (err_pulses - e0 !== 1) begin
      errors++; $display("FAIL blank_err: got %0d err pulses expected 1", err_pulses - e0);
    end
  endtask

  task automatic test_glitch_reject;
    bit saw5 = 1'b0;
    an = 4'hE; seg = 7'h12;
    for (int k = 0; k < 3; k++) begin
      step(1);
      if (digit0 == 4'd5) saw5 = 1'b1;
    end
    seg = 7'h10;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (digit0 == 4'd5) saw5 = 1'b1;
    end
    checks++;
    if (saw5 !== 1'b0 || digit0 !== 4'd9) begin
      errors++; $display("FAIL glitch: got saw5=%b d0=%0d expected 0 9", saw5, digit0);
    end
  endtask

  task automatic test_reset_mid_dwell;
    do_reset();
    an = 4'hB; seg = 7'h02;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if (digit2 !== 4'd0 || digit_valid !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_clear: got d2=%0d valid=%b expected 0 0000", digit2, digit_valid);
    end
    step(4);
    checks++;
    if (digit_valid !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_early: got valid=%b expected 0000", digit_valid);
    end
    step(1);
    checks++;
    if (digit2 !== 4'd6 || digit_valid !== 4'b0100) begin
      errors++; $display("FAIL rst_mid_accept: got d2=%0d valid=%b expected 6 0100", digit2, digit_valid);
    end
  endtask

  task automatic test_recapture;
    int f0;
    do_reset();
    f0 = fd_pulses;
    an = 4'hE; seg = 7'h79; step(5);
    an = 4'hD; seg = 7'h24; step(5);
    an = 4'hE; seg = 7'h40; step(5);
    checks++;
    if (digit0 !== 4'd0 || digit1 !== 4'd2) begin
      errors++; $display("FAIL recapture_digit: got d0=%0d d1=%0d expected 0 2", digit0, digit1);
    end
    an = 4'hB; seg = 7'h78; step(5);
    checks++;
    if (fd_pulses - f0 !== 0) begin
      errors++; $display("FAIL recapture_early_fd: got %0d expected 0", fd_pulses - f0);
    end
    an = 4'h7; seg = 7'h00; step(7);
    checks++;
    if (fd_pulses - f0 !== 1 || {digit3, digit2, digit1, digit0} !== 16'h8720) begin
      errors++; $display("FAIL recapture_frame: got fd=%0d digits=%h expected 1 8720", fd_pulses - f0, {digit3, digit2, digit1, digit0});
    end
  endtask

  task automatic test_saturation;
    int e0;
    e0 = err_pulses;
    an = 4'h7; seg = 7'h7F;
    step(300);
    checks++;
    if (err_pulses - e0 !== 1 || digit_valid[3] !== 1'b0) begin
      errors++; $display("FAIL saturation: got pulses=%0d valid3=%b expected 1 0", err_pulses - e0, digit_valid[3]);
    end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_scan_frame();
    test_illegal_seg();
    test_multi_hot_and_blank();
    test_glitch_reject();
    test_reset_mid_dwell();
    test_recapture();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
